// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
//
// Contents:
//   REG_ADDR_W     - default register address width
//   ctrl_state_t   - sequencer state (RUN, MEM_WAIT, HALT)
//   ctrl_out_t     - bundle of every combinational control output
//   ctrl_advance() - control bundle for a cycle in which the pipeline moves
package pipeline_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic pc_wr_en;
        logic if_id_wr_en;
        logic id_ex_wr_en;
        logic ex_mem_wr_en;
        logic mem_wb_wr_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_req;
    } ctrl_out_t;

    // All stage enables high with the requested bubbles; mem_req is left low
    // and is overlaid by the caller.
    function automatic ctrl_out_t ctrl_advance(input logic flush_if_id,
                                               input logic flush_id_ex);
        ctrl_out_t c;
        c              = '0;
        c.pc_wr_en     = 1'b1;
        c.if_id_wr_en  = 1'b1;
        c.id_ex_wr_en  = 1'b1;
        c.ex_mem_wr_en = 1'b1;
        c.mem_wb_wr_en = 1'b1;
        c.if_id_flush  = flush_if_id;
        c.id_ex_flush  = flush_id_ex;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_load_use_detector.sv
// Combinational load-use hazard compare.
//
// Ports:
//   ex_mem_read              - instruction in EX is a load
//   ex_rd_address            - destination register of the instruction in EX
//   id_rs1_address/_used     - first source of the instruction in ID
//   id_rs2_address/_used     - second source of the instruction in ID
//   hazard                   - ID needs the load result before it exists
module load_use_detector #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd_address,
    input  logic [REG_ADDR_W-1:0] id_rs1_address,
    input  logic                  id_rs1_used,
    input  logic [REG_ADDR_W-1:0] id_rs2_address,
    input  logic                  id_rs2_used,
    output logic                  hazard
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_rs1_used && (id_rs1_address == ex_rd_address);
    assign rs2_match = id_rs2_used && (id_rs2_address == ex_rd_address);

    // r0 is hardwired to zero, so a load targeting it produces nothing to wait for.
    assign hazard = ex_mem_read && (ex_rd_address != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
//
// Drives the pipeline-register write enables and bubble (flush) controls, runs
// the data-RAM req/ack handshake for the instruction in MEM, resolves memory
// stalls, load-use hazards and taken branches, counts stall cycles and halts
// on a data-RAM timeout.
//
// Ports:
//   clk, reset_n                      - clock, async active-low reset
//   id_rs1/rs2_address, id_rs1/2_used - sources of the instruction in ID
//   ex_rd_address, ex_mem_read        - destination / load flag of EX
//   ex_branch_taken                   - EX redirects the PC
//   mem_access, mem_ack               - MEM load/store, RAM completion pulse
//   mem_req                           - RAM request
//   pc_wr_en .. mem_wb_wr_en          - stage enables
//   if_id_flush, id_ex_flush          - load a bubble instead of data
//   mem_error                         - sticky RAM timeout flag
//   stall_cycles                      - cycles with pc_wr_en low, wraps
module pipeline_stall_controller #(
    parameter int unsigned REG_ADDR_W  = pipeline_ctrl_pkg::REG_ADDR_W,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs1_address,
    input  logic [REG_ADDR_W-1:0] id_rs2_address,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd_address,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_access,
    input  logic                  mem_ack,
    output logic                  mem_req,
    output logic                  pc_wr_en,
    output logic                  if_id_wr_en,
    output logic                  id_ex_wr_en,
    output logic                  ex_mem_wr_en,
    output logic                  mem_wb_wr_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  mem_error,
    output logic [31:0]           stall_cycles
);

    import pipeline_ctrl_pkg::*;

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

    ctrl_state_t     state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_error_q, mem_error_d;
    logic [31:0]     stall_q;

    logic      hazard;
    logic      mem_stall;
    logic      req;
    ctrl_out_t ctrl;

    load_use_detector #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detector (
        .ex_mem_read    (ex_mem_read),
        .ex_rd_address  (ex_rd_address),
        .id_rs1_address (id_rs1_address),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_address (id_rs2_address),
        .id_rs2_used    (id_rs2_used),
        .hazard         (hazard)
    );

    // Next-state logic and memory-stall decode.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = mem_error_q;
        mem_stall   = 1'b0;
        req         = 1'b0;

        unique case (state_q)
            RUN: begin
                wait_cnt_d = '0;
                if (mem_access) begin
                    req = 1'b1;
                    // Same-cycle ack is a zero-wait access: no stall at all.
                    if (!mem_ack) begin
                        mem_stall = 1'b1;
                        state_d   = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                req = 1'b1;
                // Ack is checked first so it wins over a simultaneous timeout.
                if (mem_ack) begin
                    state_d = RUN;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt_q == CntLast) begin
                        state_d     = HALT;
                        mem_error_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end
            HALT: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Output priority: reset > memory stall > branch > load-use > advance.
    always_comb begin
        ctrl = ctrl_advance(1'b0, 1'b0);
        if (mem_stall) begin
            ctrl = '0;
        end else if (ex_branch_taken) begin
            ctrl = ctrl_advance(1'b1, 1'b1);
        end else if (hazard) begin
            // Hold PC and IF/ID, send a bubble into EX.
            ctrl             = ctrl_advance(1'b0, 1'b1);
            ctrl.pc_wr_en    = 1'b0;
            ctrl.if_id_wr_en = 1'b0;
        end
        ctrl.mem_req = req;
        if (!reset_n) begin
            ctrl = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
            if (!ctrl.pc_wr_en) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign mem_req      = ctrl.mem_req;
    assign pc_wr_en     = ctrl.pc_wr_en;
    assign if_id_wr_en  = ctrl.if_id_wr_en;
    assign id_ex_wr_en  = ctrl.id_ex_wr_en;
    assign ex_mem_wr_en = ctrl.ex_mem_wr_en;
    assign mem_wb_wr_en = ctrl.mem_wb_wr_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign mem_error    = mem_error_q;
    assign stall_cycles = stall_q;

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage pipeline. It drives the `wr_en` and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC write enable. It runs the req/ack handshake to the data RAM for loads and stores in MEM. It resolves three hazard sources: multi-cycle memory stalls, load-use data hazards and taken-branch redirects. It also counts stall cycles and halts the core on a data-RAM timeout.

## Interface
- `REG_ADDR_W`, 5: register address width.
- `MEM_TIMEOUT`, 64: max cycles in MEM_WAIT before error; ≥2.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `id_rs1_address`, `id_rs2_address`  in  REG_ADDR_W  source registers of the instruction in ID.
- `id_rs1_used`, `id_rs2_used`  in  1  instruction in ID reads rs1/rs2.
- `ex_rd_address`  in  REG_ADDR_W  destination of the instruction in EX.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_branch_taken`  in  1  branch/jump in EX redirects the PC.
- `mem_access`  in  1  instruction in MEM is a load or store.
- `mem_ack`  in  1  data RAM completion pulse.
- `mem_req`  out  1  data RAM request.
- `pc_wr_en`, `if_id_wr_en`, `id_ex_wr_en`, `ex_mem_wr_en`, `mem_wb_wr_en`  out  1  stage enables.
- `if_id_flush`, `id_ex_flush`  out  1  load a bubble (zeros) instead of data.
- `mem_error`  out  1  sticky timeout flag.
- `stall_cycles`  out  32  count of cycles with `pc_wr_en`=0 while not in reset.

## Operation
- FSM states: RUN, MEM_WAIT, HALT. All outputs except `mem_error` and `stall_cycles` are combinational from the state and the inputs.
- RUN, `mem_access`=1: `mem_req`=1.
  - If `mem_ack`=1 in the same cycle, this is a zero-wait access and the pipeline advances normally.
  - Otherwise all five enables are 0 and the next state is MEM_WAIT.
- MEM_WAIT: `mem_req` is held at 1 and all enables are 0.
  - On `mem_ack`=1, all enables are 1 this cycle and the next state is RUN.
  - If the wait counter reaches MEM_TIMEOUT-1 without ack, the next state is HALT and `mem_error` sets.
- HALT: all enables 0, `mem_req`=0, no flushes. HALT is left only by reset.
- Priority in a cycle where the pipeline is not memory-stalled, highest first:
  - Branch: `ex_branch_taken`=1 gives all enables 1, `if_id_flush`=1 and `id_ex_flush`=1.
  - Load-use: `ex_mem_read`=1, `ex_rd_address`≠0, and (`id_rs1_used` with a matching `id_rs1_address`, or `id_rs2_used` with a matching `id_rs2_address`). This gives `pc_wr_en`=0, `if_id_wr_en`=0, `id_ex_flush`=1, and `id_ex_wr_en`, `ex_mem_wr_en`, `mem_wb_wr_en`=1.
  - Otherwise all enables are 1 and both flushes are 0.
- Memory stall overrides branch and load-use. `ex_branch_taken` is ignored while stalled; it is re-evaluated in the cycle of release because EX holds its instruction.
- Register address 0 never causes a load-use hazard.
- `stall_cycles` wraps modulo 2^32 and counts in all states, including HALT.

## Timing
- Enables and flushes respond to their inputs combinationally in the same cycle. State, the wait counter, `mem_error` and `stall_cycles` update on the `clk` rising edge.
- Reset asserted, asynchronous: state=RUN, wait counter=0, `mem_error`=0, `stall_cycles`=0. While `reset_n`=0, all enables, flushes and `mem_req` are forced to 0.
- Reset asserted mid-MEM_WAIT: the request drops immediately. A late `mem_ack` arriving after reset with `mem_access`=0 is ignored.
- `mem_ack` is ignored unless `mem_req`=1.
- Wait counter: 0 on entry to MEM_WAIT, +1 per cycle in MEM_WAIT. An ack in the same cycle the counter reaches MEM_TIMEOUT-1 wins over the timeout.
- Load-use stall length is exactly 1 cycle. The next cycle, the load is in MEM, so the hazard clears and a memory stall may follow.

## Structure
- Package `pipeline_ctrl_pkg`: state enum `ctrl_state_t` {RUN, MEM_WAIT, HALT} and constant `REG_ADDR_W`.
- Sub-module `load_use_detector`: combinational hazard compare, outputs `hazard`.
- Top: FSM, wait counter, priority mux, stall counter.

## Test plan
- Load r5 followed by `add r6,r5,r1`, memory ack zero-wait:
  - Cycle with the load in EX and the add in ID: `pc_wr_en`=0, `if_id_wr_en`=0, `id_ex_flush`=1.
  - Next cycle: all enables 1.
  - `stall_cycles`=1.
- Same sequence with destination r0: no stall.
- Store in MEM, `mem_ack` after 3 cycles: `mem_req` high for 4 cycles, enables 0 for 3 cycles then 1, `stall_cycles`=3.
- `ex_branch_taken`=1 together with a load-use hazard: both flushes 1 and all enables 1, so the branch wins.
- `ex_branch_taken`=1 during MEM_WAIT: no flush until the cycle `mem_ack` arrives, then both flushes are 1.
- MEM_TIMEOUT=4 with no ack: HALT after 4 MEM_WAIT cycles, `mem_error`=1, enables stay 0.
  - Assert `reset_n`=0 mid-HALT: `mem_error`=0 and state=RUN.
  - In a separate run, reset asserted during MEM_WAIT drops `mem_req` in the same cycle.
